// File: rtl/czono_pkg.sv
// Shared types and width helpers for the constrained-zonotope loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package czono_pkg;

  // Loader FSM. FLUSH covers the cycle in which the final registered write is presented.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR_N,
    ST_HDR_NG,
    ST_HDR_NC,
    ST_LOAD_C,
    ST_LOAD_G,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_FLUSH,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  // Width needed to hold a dimension value in 0..maxv.
  function automatic int dim_w(input int maxv);
    return $clog2(maxv + 1);
  endfunction

  // Address width for a RAM of the given depth (never zero).
  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/czono_idx_counter.sv
// Row/column 2-D index counter: col wraps at col_max and bumps row; row wraps at row_max.
// Latency: load/step take effect on the next clock edge; last is combinational from state.
// Backpressure: none; advances only when step is asserted, load has priority over step.
// Ports: load/row_max/col_max latch new limits and zero the indices; step advances;
//        row/col are the current indices; last flags the final (row_max, col_max) position.
module czono_idx_counter #(
  parameter int RW = 4,
  parameter int CW = 3
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          load,
  input  logic [RW-1:0] row_max,
  input  logic [CW-1:0] col_max,
  input  logic          step,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  logic [RW-1:0] row_lim;
  logic [CW-1:0] col_lim;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      row     <= '0;
      col     <= '0;
      row_lim <= '0;
      col_lim <= '0;
    end else if (load) begin
      row     <= '0;
      col     <= '0;
      row_lim <= row_max;
      col_lim <= col_max;
    end else if (step) begin
      if (col == col_lim) begin
        col <= '0;
        row <= (row == row_lim) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  assign last = (row == row_lim) && (col == col_lim);

endmodule

// File: rtl/czono_loader.sv
// Stream-to-BRAM writer for one constrained zonotope: header n, ng, nc then c, G, A, b.
// Latency: a word accepted at edge k is written (we/addr/wdata) in cycle k+1; done in cycle k+2.
// Backpressure: s_ready high only while header/load states are active; 1 word/cycle, gaps allowed.
// Ports: clk_i/rstn_i clock and async active-low reset; start begins a load from IDLE/ERR;
//        s_data/s_valid/s_ready/s_last input stream; n/ng/nc latched dimensions;
//        c_*, G_*, A_*, b_* RAM write ports; busy/done/err status.
module czono_loader
  import czono_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NMAX       = 10,
  parameter int NGMAX      = 5,
  parameter int NCMAX      = 3
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           start,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic                           s_last,
  output logic [dim_w(NMAX)-1:0]         n,
  output logic [dim_w(NGMAX)-1:0]        ng,
  output logic [dim_w(NCMAX)-1:0]        nc,
  output logic                           c_we,
  output logic [addr_w(NMAX)-1:0]        c_addr,
  output logic [DATA_WIDTH-1:0]          c_wdata,
  output logic                           G_we,
  output logic [addr_w(NMAX)-1:0]        G_raddr,
  output logic [addr_w(NGMAX)-1:0]       G_caddr,
  output logic [DATA_WIDTH-1:0]          G_wdata,
  output logic                           A_we,
  output logic [addr_w(NCMAX)-1:0]       A_raddr,
  output logic [addr_w(NGMAX)-1:0]       A_caddr,
  output logic [DATA_WIDTH-1:0]          A_wdata,
  output logic                           b_we,
  output logic [addr_w(NCMAX)-1:0]       b_addr,
  output logic [DATA_WIDTH-1:0]          b_wdata,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int NW   = dim_w(NMAX);
  localparam int GW   = dim_w(NGMAX);
  localparam int CNW  = dim_w(NCMAX);
  localparam int CAW  = addr_w(NMAX);
  localparam int GCW  = addr_w(NGMAX);
  localparam int AAW  = addr_w(NCMAX);
  localparam int RW   = (CAW > AAW) ? CAW : AAW;
  localparam int COLW = GCW;

  loader_state_t state, state_d, nxt_sec, tgt;

  logic            acc, wr_en, is_final;
  logic            n_ok, ng_ok, nc_ok;
  logic            cnt_load, cnt_step, cnt_last;
  logic [RW-1:0]   cnt_row, lim_row;
  logic [COLW-1:0] cnt_col, lim_col;

  assign acc   = s_valid && s_ready;
  assign n_ok  = (s_data != '0) && (s_data <= DATA_WIDTH'(NMAX));
  assign ng_ok = (s_data <= DATA_WIDTH'(NGMAX));
  assign nc_ok = (s_data <= DATA_WIDTH'(NCMAX));

  // Section that follows the current one; empty sections are skipped.
  always_comb begin
    nxt_sec = ST_FLUSH;
    case (state)
      ST_LOAD_C: nxt_sec = (ng != '0) ? ST_LOAD_G : ((nc != '0) ? ST_LOAD_B : ST_FLUSH);
      ST_LOAD_G: nxt_sec = (nc != '0) ? ST_LOAD_A : ST_FLUSH;
      ST_LOAD_A: nxt_sec = ST_LOAD_B;
      default:   nxt_sec = ST_FLUSH;
    endcase
  end

  // The object's final word is the last index of the last non-empty section.
  assign is_final = cnt_last && (nxt_sec == ST_FLUSH);

  // Counter limits for the section being entered. c and b are single-column.
  always_comb begin
    lim_row = '0;
    lim_col = '0;
    case (tgt)
      ST_LOAD_C: lim_row = RW'(n) - RW'(1);
      ST_LOAD_G: begin
        lim_row = RW'(n) - RW'(1);
        lim_col = COLW'(ng) - COLW'(1);
      end
      ST_LOAD_A: begin
        lim_row = RW'(nc) - RW'(1);
        lim_col = COLW'(ng) - COLW'(1);
      end
      ST_LOAD_B: lim_row = RW'(nc) - RW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= ST_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d  = state;
    s_ready  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    tgt      = ST_FLUSH;
    cnt_load = 1'b0;
    cnt_step = 1'b0;
    wr_en    = 1'b0;
    case (state)
      ST_IDLE: if (start) state_d = ST_HDR_N;
      ST_HDR_N: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (acc) state_d = (s_last || !n_ok) ? ST_ERR : ST_HDR_NG;
      end
      ST_HDR_NG: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (acc) state_d = (s_last || !ng_ok) ? ST_ERR : ST_HDR_NC;
      end
      ST_HDR_NC: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (acc) begin
          if (s_last || !nc_ok) begin
            state_d = ST_ERR;
          end else begin
            state_d  = ST_LOAD_C;
            tgt      = ST_LOAD_C;
            cnt_load = 1'b1;
          end
        end
      end
      ST_LOAD_C, ST_LOAD_G, ST_LOAD_A, ST_LOAD_B: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (acc) begin
          // A misplaced or missing s_last is caught on the offending word, which is dropped.
          if (s_last != is_final) begin
            state_d = ST_ERR;
          end else begin
            wr_en    = 1'b1;
            cnt_step = 1'b1;
            if (cnt_last) begin
              state_d  = nxt_sec;
              tgt      = nxt_sec;
              cnt_load = (nxt_sec != ST_FLUSH);
            end
          end
        end
      end
      ST_FLUSH: begin
        busy    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err = 1'b1;
        if (start) state_d = ST_HDR_N;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  czono_idx_counter #(
    .RW(RW),
    .CW(COLW)
  ) u_idx (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .load   (cnt_load),
    .row_max(lim_row),
    .col_max(lim_col),
    .step   (cnt_step),
    .row    (cnt_row),
    .col    (cnt_col),
    .last   (cnt_last)
  );

  // Dimensions are latched only when the header word is valid.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      n  <= '0;
      ng <= '0;
      nc <= '0;
    end else if (acc && !s_last) begin
      if (state == ST_HDR_N  && n_ok)  n  <= NW'(s_data);
      if (state == ST_HDR_NG && ng_ok) ng <= GW'(s_data);
      if (state == ST_HDR_NC && nc_ok) nc <= CNW'(s_data);
    end
  end

  // One registered write per accepted payload word.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      c_we    <= 1'b0;
      c_addr  <= '0;
      c_wdata <= '0;
      G_we    <= 1'b0;
      G_raddr <= '0;
      G_caddr <= '0;
      G_wdata <= '0;
      A_we    <= 1'b0;
      A_raddr <= '0;
      A_caddr <= '0;
      A_wdata <= '0;
      b_we    <= 1'b0;
      b_addr  <= '0;
      b_wdata <= '0;
    end else begin
      c_we <= wr_en && (state == ST_LOAD_C);
      G_we <= wr_en && (state == ST_LOAD_G);
      A_we <= wr_en && (state == ST_LOAD_A);
      b_we <= wr_en && (state == ST_LOAD_B);
      if (wr_en && state == ST_LOAD_C) begin
        c_addr  <= CAW'(cnt_row);
        c_wdata <= s_data;
      end
      if (wr_en && state == ST_LOAD_G) begin
        G_raddr <= CAW'(cnt_row);
        G_caddr <= GCW'(cnt_col);
        G_wdata <= s_data;
      end
      if (wr_en && state == ST_LOAD_A) begin
        A_raddr <= AAW'(cnt_row);
        A_caddr <= GCW'(cnt_col);
        A_wdata <= s_data;
      end
      if (wr_en && state == ST_LOAD_B) begin
        b_addr  <= AAW'(cnt_row);
        b_wdata <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_czono_loader.sv
// Directed bench for czono_loader: full loads, valid gaps, empty sections, malformed streams, reset.
// Latency: checks done two cycles after the final accept.
// Backpressure: stimulus holds each word until s_ready accepts it, bounded by a cycle budget.
module tb_czono_loader;

  logic        clk_tb = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] s_data;
  logic        s_valid, s_ready, s_last;
  logic [3:0]  n;
  logic [2:0]  ng;
  logic [1:0]  nc;
  logic        c_we, G_we, A_we, b_we;
  logic [3:0]  c_addr, G_raddr;
  logic [2:0]  G_caddr, A_caddr;
  logic [1:0]  A_raddr, b_addr;
  logic [31:0] c_wdata, G_wdata, A_wdata, b_wdata;
  logic        busy, done, err;

  czono_loader dut (
    .clk_i(clk_tb), .rstn_i(rst_n), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .n(n), .ng(ng), .nc(nc),
    .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .G_we(G_we), .G_raddr(G_raddr), .G_caddr(G_caddr), .G_wdata(G_wdata),
    .A_we(A_we), .A_raddr(A_raddr), .A_caddr(A_caddr), .A_wdata(A_wdata),
    .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk_tb = ~clk_tb;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // RAM model filled from the DUT write ports.
  logic [31:0] c_mem [16];
  logic [31:0] G_mem [16][8];
  logic [31:0] A_mem [4][8];
  logic [31:0] b_mem [4];
  int c_wr, G_wr, A_wr, b_wr, multi_we, err_wr, done_cnt, done_cyc;
  int cyc = 0;

  always @(posedge clk_tb) begin
    if (c_we) begin c_mem[c_addr] = c_wdata; c_wr++; end
    if (G_we) begin G_mem[G_raddr][G_caddr] = G_wdata; G_wr++; end
    if (A_we) begin A_mem[A_raddr][A_caddr] = A_wdata; A_wr++; end
    if (b_we) begin b_mem[b_addr] = b_wdata; b_wr++; end
    if ((int'(c_we) + int'(G_we) + int'(A_we) + int'(b_we)) > 1) multi_we++;
    if (err && (c_we || G_we || A_we || b_we)) err_wr++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    cyc++;
  end

  logic [31:0] stim [32];

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      c_mem[i] = 32'hDEADBEEF;
      for (int j = 0; j < 8; j++) G_mem[i][j] = 32'hDEADBEEF;
    end
    for (int i = 0; i < 4; i++) begin
      b_mem[i] = 32'hDEADBEEF;
      for (int j = 0; j < 8; j++) A_mem[i][j] = 32'hDEADBEEF;
    end
    c_wr = 0; G_wr = 0; A_wr = 0; b_wr = 0; multi_we = 0; done_cnt = 0; done_cyc = -1;
  endtask

  // n=2 ng=3 nc=1: c{5.0,0.5} G{0.5,1,-0.5 / 0.5,0.5,0} A{0.5,1,-0.5} b{1.0}
  task automatic load_obj1();
    logic [31:0] w [15];
    w = '{32'd2, 32'd3, 32'd1,
          32'h40A00000, 32'h3F000000,
          32'h3F000000, 32'h3F800000, 32'hBF000000, 32'h3F000000, 32'h3F000000, 32'h00000000,
          32'h3F000000, 32'h3F800000, 32'hBF000000,
          32'h3F800000};
    for (int i = 0; i < 15; i++) stim[i] = w[i];
  endtask

  // Number of cells / write counts that differ from object 1.
  function automatic int obj1_mismatches();
    int m = 0;
    if (c_mem[0] !== 32'h40A00000) m++;
    if (c_mem[1] !== 32'h3F000000) m++;
    if (G_mem[0][0] !== 32'h3F000000) m++;
    if (G_mem[0][1] !== 32'h3F800000) m++;
    if (G_mem[0][2] !== 32'hBF000000) m++;
    if (G_mem[1][0] !== 32'h3F000000) m++;
    if (G_mem[1][1] !== 32'h3F000000) m++;
    if (G_mem[1][2] !== 32'h00000000) m++;
    if (A_mem[0][0] !== 32'h3F000000) m++;
    if (A_mem[0][1] !== 32'h3F800000) m++;
    if (A_mem[0][2] !== 32'hBF000000) m++;
    if (b_mem[0] !== 32'h3F800000) m++;
    if (c_wr != 2 || G_wr != 6 || A_wr != 3 || b_wr != 1) m++;
    return m;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(posedge clk_tb); #1;
    start = 1'b0;
  endtask

  // Offers stim[0..len-1], s_last on index last_pos; with gaps s_valid drops every other cycle.
  task automatic send_words(input int len, input int last_pos, input bit gaps,
                            output int last_edge);
    int  i = 0;
    int  guard = 0;
    bit  tog = 1'b1;
    bit  acc;
    last_edge = -1;
    while (i < len && guard < 200) begin
      s_valid = gaps ? tog : 1'b1;
      s_data  = stim[i];
      s_last  = (i == last_pos);
      @(negedge clk_tb);
      acc = s_valid && s_ready;
      @(posedge clk_tb); #1;
      if (acc) begin
        i++;
        last_edge = cyc - 1;
      end
      tog = ~tog;
      guard++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk_cnt++;
    if (i !== len) $display("FAIL send_timeout: accepted %0d words, required %0d", i, len);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    chk_cnt++;
    if ({s_ready, busy, done, err} !== 4'b0) $display("FAIL reset_status: got %b, required 0000", {s_ready, busy, done, err});
    else pass_cnt++;
    chk_cnt++;
    if ({c_we, G_we, A_we, b_we} !== 4'b0) $display("FAIL reset_we: got %b, required 0000", {c_we, G_we, A_we, b_we});
    else pass_cnt++;
    chk_cnt++;
    if ({n, ng, nc} !== 9'd0) $display("FAIL reset_dims: got %h, required 0", {n, ng, nc});
    else pass_cnt++;
    chk_cnt++;
    if ({c_addr, G_raddr, G_caddr, A_raddr, A_caddr, b_addr, c_wdata, G_wdata, A_wdata, b_wdata} !== '0)
      $display("FAIL reset_addr_data: nonzero address/data after reset, required 0");
    else pass_cnt++;
  endtask

  task automatic test_load(input bit gaps, input string tag);
    int le;
    clear_model();
    load_obj1();
    do_start();
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL %s_busy: got %b, required 1", tag, busy);
    else pass_cnt++;
    send_words(15, 14, gaps, le);
    repeat (5) @(posedge clk_tb);
    #1;
    chk_cnt++;
    if (obj1_mismatches() !== 0) $display("FAIL %s_ram: %0d mismatches, required 0", tag, obj1_mismatches());
    else pass_cnt++;
    chk_cnt++;
    if ({n, ng, nc} !== {4'd2, 3'd3, 2'd1}) $display("FAIL %s_dims: got n=%0d ng=%0d nc=%0d, required 2 3 1", tag, n, ng, nc);
    else pass_cnt++;
    chk_cnt++;
    if (done_cnt !== 1) $display("FAIL %s_done_count: got %0d, required 1", tag, done_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (done_cyc !== le + 2) $display("FAIL %s_done_latency: done at %0d, required %0d", tag, done_cyc, le + 2);
    else pass_cnt++;
    chk_cnt++;
    if ({err, busy, multi_we} !== {1'b0, 1'b0, 32'd0}) $display("FAIL %s_status: err=%b busy=%b multi_we=%0d, required 0 0 0", tag, err, busy, multi_we);
    else pass_cnt++;
  endtask

  task automatic test_no_constraints();
    int le;
    logic [31:0] w [9];
    w = '{32'd2, 32'd2, 32'd0, 32'h3F800000, 32'h40A00000,
          32'h3F000000, 32'hBF000000, 32'h3F800000, 32'h00000000};
    for (int i = 0; i < 9; i++) stim[i] = w[i];
    clear_model();
    do_start();
    send_words(9, 8, 1'b0, le);
    repeat (5) @(posedge clk_tb);
    #1;
    chk_cnt++;
    if ({A_wr, b_wr} !== 64'd0) $display("FAIL nc0_ab_writes: A=%0d b=%0d, required 0 0", A_wr, b_wr);
    else pass_cnt++;
    chk_cnt++;
    if ({G_mem[0][0], G_mem[0][1], G_mem[1][0], G_mem[1][1]} !== {32'h3F000000, 32'hBF000000, 32'h3F800000, 32'h0})
      $display("FAIL nc0_G: got %h %h %h %h, required 3f000000 bf000000 3f800000 0", G_mem[0][0], G_mem[0][1], G_mem[1][0], G_mem[1][1]);
    else pass_cnt++;
    chk_cnt++;
    if ({c_mem[0], c_mem[1], c_wr, G_wr} !== {32'h3F800000, 32'h40A00000, 32'd2, 32'd4})
      $display("FAIL nc0_c: got %h %h writes c=%0d G=%0d", c_mem[0], c_mem[1], c_wr, G_wr);
    else pass_cnt++;
    chk_cnt++;
    if (done_cnt !== 1 || done_cyc !== le + 2) $display("FAIL nc0_done: count=%0d at %0d, required 1 at %0d", done_cnt, done_cyc, le + 2);
    else pass_cnt++;
    chk_cnt++;
    if ({n, ng, nc} !== {4'd2, 3'd2, 2'd0}) $display("FAIL nc0_dims: got n=%0d ng=%0d nc=%0d, required 2 2 0", n, ng, nc);
    else pass_cnt++;
  endtask

  task automatic test_bad_header();
    int le;
    clear_model();
    stim[0] = 32'd0;
    do_start();
    send_words(1, -1, 1'b0, le);
    repeat (3) @(posedge clk_tb);
    #1;
    chk_cnt++;
    if ({err, s_ready, busy} !== 3'b100) $display("FAIL hdr_n0: err/s_ready/busy=%b, required 100", {err, s_ready, busy});
    else pass_cnt++;
    chk_cnt++;
    if (c_wr + G_wr + A_wr + b_wr !== 0) $display("FAIL hdr_n0_writes: got %0d, required 0", c_wr + G_wr + A_wr + b_wr);
    else pass_cnt++;
    do_start();
    chk_cnt++;
    if ({err, busy} !== 2'b01) $display("FAIL err_clear: err/busy=%b, required 01", {err, busy});
    else pass_cnt++;
    stim[0] = 32'd2;
    stim[1] = 32'd6;
    send_words(2, -1, 1'b0, le);
    repeat (3) @(posedge clk_tb);
    #1;
    chk_cnt++;
    if ({err, s_ready, busy} !== 3'b100) $display("FAIL hdr_ng6: err/s_ready/busy=%b, required 100", {err, s_ready, busy});
    else pass_cnt++;
    chk_cnt++;
    if (c_wr + G_wr + A_wr + b_wr + done_cnt !== 0) $display("FAIL hdr_ng6_writes: got %0d, required 0", c_wr + G_wr + A_wr + b_wr + done_cnt);
    else pass_cnt++;
    test_load(1'b0, "after_err");
  endtask

  task automatic test_last_errors();
    int le;
    clear_model();
    load_obj1();
    do_start();
    send_words(10, 9, 1'b0, le);
    repeat (3) @(posedge clk_tb);
    #1;
    chk_cnt++;
    if ({err, s_ready, done_cnt} !== {1'b1, 1'b0, 32'd0}) $display("FAIL early_last: err=%b s_ready=%b done=%0d, required 1 0 0", err, s_ready, done_cnt);
    else pass_cnt++;
    clear_model();
    do_start();
    send_words(15, -1, 1'b0, le);
    repeat (3) @(posedge clk_tb);
    #1;
    chk_cnt++;
    if ({err, s_ready, done_cnt} !== {1'b1, 1'b0, 32'd0}) $display("FAIL missing_last: err=%b s_ready=%b done=%0d, required 1 0 0", err, s_ready, done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int le;
    clear_model();
    load_obj1();
    do_start();
    send_words(7, -1, 1'b0, le);
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({s_ready, busy, done, err, c_we, G_we, A_we, b_we} !== 8'b0) $display("FAIL midreset_ctrl: got %b, required 0", {s_ready, busy, done, err, c_we, G_we, A_we, b_we});
    else pass_cnt++;
    chk_cnt++;
    if ({n, ng, nc, G_raddr, G_caddr, G_wdata} !== '0) $display("FAIL midreset_dims: n=%0d ng=%0d nc=%0d G_wdata=%h, required 0", n, ng, nc, G_wdata);
    else pass_cnt++;
    @(posedge clk_tb); #1;
    rst_n = 1'b1;
    @(posedge clk_tb); #1;
    test_load(1'b0, "after_reset");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    err_wr = 0;
    clear_model();
    repeat (3) @(posedge clk_tb);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk_tb); #1;
    test_load(1'b0, "obj1");
    test_load(1'b1, "gaps");
    test_no_constraints();
    test_bad_header();
    test_last_errors();
    test_reset_mid();
    chk_cnt++;
    if (err_wr !== 0) $display("FAIL writes_in_err: got %0d, required 0", err_wr);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
